// File: rtl/iterative_mul_unit_if.sv
// iterative_mul_unit_if: launch/result bundle between the EX-stage ALU and the multiplier.
interface iterative_mul_unit_if #(parameter int XLEN = 32);
   logic            mul_start;
   logic [4:0]      alu_opE;
   logic [XLEN-1:0] SrcAE;
   logic [XLEN-1:0] SrcBE;
   logic            flush;
   logic [XLEN-1:0] result_m;
   logic            flagM;
   logic            mul_busy;
   modport master (output mul_start, alu_opE, SrcAE, SrcBE, flush, input result_m, flagM, mul_busy);
   modport slave (input mul_start, alu_opE, SrcAE, SrcBE, flush, output result_m, flagM, mul_busy);
endinterface

// File: rtl/iterative_mul_unit.sv
// iterative_mul_unit: radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU,
// magnitude multiply over XLEN cycles with a final sign fix-up.
module iterative_mul_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input logic clk,
   input logic rst_n,
   iterative_mul_unit_if.slave bus
);
   localparam logic [4:0] OP_MUL    = 5'b01011;
   localparam logic [4:0] OP_MULH   = 5'b01100;
   localparam logic [4:0] OP_MULHSU = 5'b01101;
   localparam logic [4:0] OP_MULHU  = 5'b01110;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t            state;
   logic [CNT_W-1:0]  counter;
   logic [XLEN-1:0]   mcand, mplier, prod_hi;
   logic              neg;
   logic [4:0]        op;
   logic              is_mul, a_neg, b_neg;
   logic [XLEN-1:0]   a_abs, b_abs, sel;
   logic [XLEN:0]     sum;
   logic [2*XLEN-1:0] p_fin, prod;
   assign is_mul = bus.alu_opE inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
   assign a_neg  = (bus.alu_opE != OP_MULHU) & bus.SrcAE[XLEN-1];
   assign b_neg  = (bus.alu_opE inside {OP_MUL, OP_MULH}) & bus.SrcBE[XLEN-1];
   assign a_abs  = a_neg ? -bus.SrcAE : bus.SrcAE;
   assign b_abs  = b_neg ? -bus.SrcBE : bus.SrcBE;
   assign sum    = {1'b0, prod_hi} + (mcand[0] ? {1'b0, mplier} : '0);
   // p_fin is the shifted {carry, product_hi, mcand}; on the last step it is the full magnitude
   assign p_fin  = {sum, mcand[XLEN-1:1]};
   assign prod   = neg ? -p_fin : p_fin;
   assign sel    = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   assign bus.mul_busy = (state == IDLE && bus.mul_start && is_mul) || state == CALC;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         counter      <= '0;
         mcand        <= '0;
         mplier       <= '0;
         prod_hi      <= '0;
         neg          <= 1'b0;
         op           <= '0;
         bus.result_m <= '0;
         bus.flagM    <= 1'b0;
      end else begin
         bus.flagM <= 1'b0;
         if (bus.flush) state <= IDLE;
         else case (state)
            IDLE: if (bus.mul_start && is_mul) begin
               mcand   <= a_abs;
               mplier  <= b_abs;
               prod_hi <= '0;
               neg     <= a_neg ^ b_neg;
               op      <= bus.alu_opE;
               counter <= '0;
               state   <= CALC;
            end
            CALC: begin
               {prod_hi, mcand} <= p_fin;
               counter          <= counter + 1'b1;
               if (counter == CNT_W'(XLEN-1)) begin
                  bus.result_m <= sel;
                  bus.flagM    <= 1'b1;
                  state        <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iterative_mul_unit.sv
// tb_iterative_mul_unit: random and directed ops against a 64-bit arithmetic model,
// checked by a flagM-driven scoreboard monitor.
module tb_iterative_mul_unit;
   localparam logic [4:0] MUL = 5'b01011, MULH = 5'b01100, MULHSU = 5'b01101, MULHU = 5'b01110, ADD = 5'b00000;
   typedef struct {logic [31:0] res; int cyc;} exp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   int cyc = 0, total = 0, bad = 0;
   logic [31:0] last_res = '0;
   logic [4:0] ops[4] = '{MUL, MULH, MULHSU, MULHU};
   logic [31:0] specials[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
   exp_t q[$];
   exp_t mon_e;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   iterative_mul_unit_if #(.XLEN(32)) bus();
   iterative_mul_unit #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   function automatic logic [31:0] ref_mul(logic [4:0] op, logic [31:0] a, logic [31:0] b);
      logic [63:0] sa, sb, p;
      sa = (op == MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
      sb = (op == MUL || op == MULH) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = sa * sb;
      return (op == MUL) ? p[31:0] : p[63:32];
   endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask
   always @(negedge clk) if (rst_n && bus.flagM) begin
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_flagM: got flagM=1 result_m=%0h want no result", bus.result_m);
      end else begin
         mon_e = q.pop_front();
         chk("result_m", 64'(bus.result_m), 64'(mon_e.res));
         chk("latency", 64'(cyc), 64'(mon_e.cyc));
         chk("busy_in_done", 64'(bus.mul_busy), 64'(0));
         last_res = mon_e.res;
      end
   end
   task automatic launch(logic [4:0] op, logic [31:0] a, logic [31:0] b);
      logic m;
      m = op inside {MUL, MULH, MULHSU, MULHU};
      @(negedge clk);
      bus.mul_start = 1'b1;
      bus.alu_opE   = op;
      bus.SrcAE     = a;
      bus.SrcBE     = b;
      #1 chk("busy_launch", 64'(bus.mul_busy), 64'(m));
      @(posedge clk);
      #1;
      if (m) q.push_back('{ref_mul(op, a, b), cyc + 32});
      bus.mul_start = 1'b0;
      bus.SrcAE     = $urandom;
      bus.SrcBE     = $urandom;
      bus.alu_opE   = 5'($urandom);
   endtask
   task automatic drain();
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL timeout: %0d results outstanding, want 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask
   task automatic run(logic [4:0] op, logic [31:0] a, logic [31:0] b);
      launch(op, a, b);
      drain();
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end
   initial begin
      logic [31:0] a, b;
      bus.mul_start = 1'b0;
      bus.flush     = 1'b0;
      bus.alu_opE   = '0;
      bus.SrcAE     = '0;
      bus.SrcBE     = '0;
      #12;
      chk("reset_result", 64'(bus.result_m), 64'(0));
      chk("reset_flag", 64'(bus.flagM), 64'(0));
      chk("reset_busy", 64'(bus.mul_busy), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run(MUL, 32'd7, 32'd6);
      run(MULH, 32'h80000000, 32'h80000000);
      run(MUL, 32'hFFFFFFFF, 32'h2);
      run(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run(MULH, 32'h0, 32'h12345678);
      launch(ADD, 32'd5, 32'd6);
      repeat (40) @(negedge clk);
      chk("ignored_op_hold", 64'(bus.result_m), 64'(last_res));
      launch(MUL, 32'd123, 32'd456);
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      q.delete();
      @(negedge clk);
      chk("flush_busy", 64'(bus.mul_busy), 64'(0));
      chk("flush_hold", 64'(bus.result_m), 64'(last_res));
      repeat (40) @(negedge clk);
      run(MUL, 32'd3, 32'd5);
      launch(MULHU, 32'd9, 32'd11);
      repeat (33) @(negedge clk);
      bus.mul_start = 1'b1;
      bus.alu_opE   = MUL;
      #1 chk("busy_start_in_done", 64'(bus.mul_busy), 64'(0));
      @(posedge clk);
      #1 bus.mul_start = 1'b0;
      repeat (40) @(negedge clk);
      chk("done_start_ignored", 64'(q.size()), 64'(0));
      launch(MULH, $urandom, $urandom);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_result", 64'(bus.result_m), 64'(0));
      chk("async_rst_flag", 64'(bus.flagM), 64'(0));
      chk("async_rst_busy", 64'(bus.mul_busy), 64'(0));
      q.delete();
      last_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      run(MULHU, 32'd2, 32'd3);
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         run(ops[$urandom_range(0, 3)], a, b);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
